echo_repeat_fifo: RTL

//   Parametrised successor to the single-entry echo block: buffers 'say' requests in a

---
 rtl/echo_repeat_fifo.sv | 87 ++++++++
 1 files changed

// File: rtl/echo_repeat_fifo.sv
// DEPTH-entry FIFO of 'say' requests; each head word is replayed through ind_heard
// a per-entry number of times (0 treated as 1), tagged with its 0-based repeat index.
module echo_repeat_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REPW  = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             say__ENA,
  input  logic [WIDTH-1:0] say_v,
  input  logic [REPW-1:0]  say_rep,
  output logic             say__RDY,
  input  logic             respond_rule__ENA,
  output logic             respond_rule__RDY,
  output logic             ind_heard__ENA,
  output logic [WIDTH-1:0] ind_heard_v,
  output logic [REPW-1:0]  ind_heard_idx,
  input  logic             ind_heard__RDY,
  output logic [AW:0]      occupancy,
  output logic [31:0]      heard_count
);

  localparam logic [AW:0]     FullCnt = DEPTH[AW:0];
  localparam logic [AW:0]     OccOne  = 1;
  localparam logic [AW-1:0]   PtrOne  = 1;
  localparam logic [REPW-1:0] RepOne  = 1;

  logic [WIDTH-1:0] mem_v_q   [DEPTH];
  logic [REPW-1:0]  mem_rep_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     occ_q;
  logic [REPW-1:0] idx_q;
  logic [31:0]     heard_cnt_q;

  logic            enq, fire, pop;
  logic [REPW-1:0] rep_eff, head_rep;

  always_comb begin
    say__RDY          = !RST && (occ_q != FullCnt);
    respond_rule__RDY = !RST && (occ_q != '0) && ind_heard__RDY;
    enq               = say__ENA && say__RDY;
    fire              = respond_rule__ENA && respond_rule__RDY;
    head_rep          = mem_rep_q[rd_ptr_q];
    pop               = fire && (idx_q == head_rep - RepOne);
    rep_eff           = (say_rep == '0) ? RepOne : say_rep;
    ind_heard__ENA    = fire;
    ind_heard_v       = mem_v_q[rd_ptr_q];
    ind_heard_idx     = idx_q;
    occupancy         = occ_q;
    heard_count       = heard_cnt_q;
  end

  // Storage has no reset: entries are only observable once occupancy covers them.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_v_q[wr_ptr_q]   <= say_v;
      mem_rep_q[wr_ptr_q] <= rep_eff;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      idx_q       <= '0;
      heard_cnt_q <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (fire) begin
        heard_cnt_q <= heard_cnt_q + 32'd1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrOne;
          idx_q    <= '0;
        end else begin
          idx_q <= idx_q + RepOne;
        end
      end
      if (enq && !pop)      occ_q <= occ_q + OccOne;
      else if (pop && !enq) occ_q <= occ_q - OccOne;
    end
  end

endmodule
